// File: rtl/ahb_lite_arbiter.sv
// ahb_lite_arbiter: two-master AHB-lite arbiter. Each master owns a one-deep
// hold register and a small FSM that stalls it through its own HREADY. One
// shared issue register drives the slave-side address phase. All master
// bursts leave as SINGLE transfers.
// Optional feature macro: AHB_ARB_LOCK_EN (HMASTLOCK-based bus locking).

// Per-master port: captures one address phase and tracks it to completion
module ahb_arb_port #(
  parameter int RW = 41
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req,      // master HTRANS[1]: NONSEQ/SEQ
  input  logic [RW-1:0] req_ctl,  // {lock, prot, size, write, addr}
  input  logic          hready,
  input  logic          grant,    // already qualified with slave HREADY
  output logic          held,
  output logic          in_data,
  output logic [RW-1:0] hold,
  output logic          mready
);
  typedef enum logic [1:0] {IDLE, HELD, ADDR, DATA} st_t;
  st_t  st, st_nxt;
  logic cap;

  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) st <= IDLE;
    else     st <= st_nxt;

  // next state, capture strobe and master-side ready
  always_comb begin
    st_nxt = st;
    cap    = 1'b0;
    mready = 1'b1;
    case (st)
      IDLE: if (req) begin cap = 1'b1; st_nxt = HELD; end
      HELD: begin mready = 1'b0; if (grant) st_nxt = ADDR; end
      ADDR: begin mready = 1'b0; if (hready) st_nxt = DATA; end
      DATA: begin
        // completion cycle doubles as the accept cycle for the next address
        mready = hready;
        if (hready) begin
          cap    = req;
          st_nxt = req ? HELD : IDLE;
        end
      end
      default: st_nxt = IDLE;
    endcase
  end

  // one-deep hold register for the captured address phase
  always_ff @(posedge clk or posedge rst)
    if (rst)      hold <= '0;
    else if (cap) hold <= req_ctl;

  assign held    = (st == HELD);
  assign in_data = (st == DATA);
endmodule

// Top: lane array of master ports, round-robin grant, shared issue register
module ahb_lite_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          HCLK,
  input  logic          HRESET,
  input  logic [1:0]    M0_HTRANS,
  input  logic [AW-1:0] M0_HADDR,
  input  logic          M0_HWRITE,
  input  logic [2:0]    M0_HSIZE,
  input  logic [3:0]    M0_HPROT,
  input  logic          M0_HMASTLOCK,
  input  logic [DW-1:0] M0_HWDATA,
  output logic          M0_HREADY,
  output logic          M0_HRESP,
  output logic [DW-1:0] M0_HRDATA,
  input  logic [1:0]    M1_HTRANS,
  input  logic [AW-1:0] M1_HADDR,
  input  logic          M1_HWRITE,
  input  logic [2:0]    M1_HSIZE,
  input  logic [3:0]    M1_HPROT,
  input  logic          M1_HMASTLOCK,
  input  logic [DW-1:0] M1_HWDATA,
  output logic          M1_HREADY,
  output logic          M1_HRESP,
  output logic [DW-1:0] M1_HRDATA,
  output logic [1:0]    HTRANS,
  output logic [2:0]    HBURST,
  output logic [AW-1:0] HADDR,
  output logic          HWRITE,
  output logic [2:0]    HSIZE,
  output logic [3:0]    HPROT,
  output logic          HMASTLOCK,
  output logic [DW-1:0] HWDATA,
  input  logic          HREADY,
  input  logic          HRESP,
  input  logic [DW-1:0] HRDATA
);
  localparam int NUM_LANES = 2;
  localparam int RW        = AW + 9;

  logic [NUM_LANES-1:0]         req, held, in_data, grant, mready, elig;
  logic [NUM_LANES-1:0][RW-1:0] req_ctl, hold;
  logic                         win, go, last_grant, iss_vld;
  logic [RW-1:0]                iss;

  assign req        = {M1_HTRANS[1], M0_HTRANS[1]};
  assign req_ctl[0] = {M0_HMASTLOCK, M0_HPROT, M0_HSIZE, M0_HWRITE, M0_HADDR};
  assign req_ctl[1] = {M1_HMASTLOCK, M1_HPROT, M1_HSIZE, M1_HWRITE, M1_HADDR};

  generate
    for (genvar g = 0; g < NUM_LANES; g++) begin : g_port
      ahb_arb_port #(.RW(RW)) u_port (
        .clk     (HCLK),
        .rst     (HRESET),
        .req     (req[g]),
        .req_ctl (req_ctl[g]),
        .hready  (HREADY),
        .grant   (grant[g]),
        .held    (held[g]),
        .in_data (in_data[g]),
        .hold    (hold[g]),
        .mready  (mready[g])
      );
    end
  endgenerate

`ifdef AHB_ARB_LOCK_EN
  logic lock_vld, lock_own;
  logic unused_ok;
  assign unused_ok = ^{M0_HTRANS[0], M1_HTRANS[0]};

  // lock owner tracking: set by a locked issue, cleared by the owner's unlocked issue
  always_ff @(posedge HCLK or posedge HRESET)
    if (HRESET) begin
      lock_vld <= 1'b0;
      lock_own <= 1'b0;
    end else if (go) begin
      if (hold[win][RW-1]) begin
        lock_vld <= 1'b1;
        lock_own <= win;
      end else if (lock_own == win) begin
        lock_vld <= 1'b0;
      end
    end

  assign HMASTLOCK = iss[RW-1];
`else
  logic unused_ok;
  assign unused_ok = ^{M0_HTRANS[0], M1_HTRANS[0], iss[RW-1]};
  assign HMASTLOCK = 1'b0;
`endif

  // arbitration: round-robin only when both are held; grant needs slave HREADY
  always_comb begin
    elig = held;
`ifdef AHB_ARB_LOCK_EN
    if (lock_vld) elig = held & (lock_own ? 2'b10 : 2'b01);
`endif
    win        = (&elig) ? ~last_grant : elig[1];
    go         = (|elig) & HREADY;
    grant      = '0;
    grant[win] = go;
  end

  // last_grant remembers the winner of the last contested arbitration
  always_ff @(posedge HCLK or posedge HRESET)
    if (HRESET)                 last_grant <= 1'b1;
    else if (go && (&elig))     last_grant <= win;

  // issue register: slave address phase, advances only when the slave is ready
  always_ff @(posedge HCLK or posedge HRESET)
    if (HRESET) begin
      iss_vld <= 1'b0;
      iss     <= '0;
    end else if (HREADY) begin
      iss_vld <= go;
      iss     <= go ? hold[win] : '0;
    end

  assign HTRANS                        = {iss_vld, 1'b0};
  assign HBURST                        = 3'b000;
  assign {HPROT, HSIZE, HWRITE, HADDR} = iss[RW-2:0];
  assign HWDATA = in_data[0] ? M0_HWDATA : (in_data[1] ? M1_HWDATA : '0);

  assign M0_HREADY = mready[0];
  assign M0_HRESP  = in_data[0] & HRESP;
  assign M0_HRDATA = in_data[0] ? HRDATA : '0;
  assign M1_HREADY = mready[1];
  assign M1_HRESP  = in_data[1] & HRESP;
  assign M1_HRDATA = in_data[1] ? HRDATA : '0;
endmodule

// File: tb/tb_ahb_lite_arbiter.sv
// Bench for ahb_lite_arbiter: per-cycle vector table plus hand-written
// reset sequences. Expectations follow AHB_ARB_LOCK_EN when it is defined.
module tb_ahb_lite_arbiter;
  localparam logic [31:0] D0 = 32'hDEADBEEF;
  localparam logic [31:0] D1 = 32'hCAFEF00D;
`ifdef AHB_ARB_LOCK_EN
  localparam logic LK = 1'b1;
`else
  localparam logic LK = 1'b0;
`endif

  logic        HCLK = 1'b0, HRESET = 1'b1;
  logic [1:0]  M0_HTRANS, M1_HTRANS, HTRANS;
  logic [31:0] M0_HADDR, M1_HADDR, HADDR, M0_HWDATA, M1_HWDATA, HWDATA;
  logic [31:0] M0_HRDATA, M1_HRDATA, HRDATA;
  logic        M0_HWRITE, M1_HWRITE, M0_HMASTLOCK, M1_HMASTLOCK;
  logic [2:0]  M0_HSIZE, M1_HSIZE, HSIZE, HBURST;
  logic [3:0]  M0_HPROT, M1_HPROT, HPROT;
  logic        M0_HREADY, M0_HRESP, M1_HREADY, M1_HRESP;
  logic        HWRITE, HMASTLOCK, HREADY, HRESP;

  always #5 HCLK = ~HCLK;

  ahb_lite_arbiter #(.AW(32), .DW(32)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .M0_HTRANS(M0_HTRANS), .M0_HADDR(M0_HADDR), .M0_HWRITE(M0_HWRITE),
    .M0_HSIZE(M0_HSIZE), .M0_HPROT(M0_HPROT), .M0_HMASTLOCK(M0_HMASTLOCK),
    .M0_HWDATA(M0_HWDATA), .M0_HREADY(M0_HREADY), .M0_HRESP(M0_HRESP),
    .M0_HRDATA(M0_HRDATA),
    .M1_HTRANS(M1_HTRANS), .M1_HADDR(M1_HADDR), .M1_HWRITE(M1_HWRITE),
    .M1_HSIZE(M1_HSIZE), .M1_HPROT(M1_HPROT), .M1_HMASTLOCK(M1_HMASTLOCK),
    .M1_HWDATA(M1_HWDATA), .M1_HREADY(M1_HREADY), .M1_HRESP(M1_HRESP),
    .M1_HRDATA(M1_HRDATA),
    .HTRANS(HTRANS), .HBURST(HBURST), .HADDR(HADDR), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
    .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
  );

  // one clock cycle: stimulus and expected outputs sampled in that cycle
  typedef struct {
    logic [31:0] t0, a0, w0, l0, t1, a1, w1, l1, rdy, rsp, rd;
    logic [31:0] et, ea, ew, el, ewd, r0, s0, rd0, r1, s1, rd1;
  } vec_t;

  vec_t vq[$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mk(
    input logic [31:0] t0, a0, w0, l0, t1, a1, w1, l1, rdy, rsp, rd,
    input logic [31:0] et, ea, ew, el, ewd, r0, s0, rd0, r1, s1, rd1);
    vec_t v;
    v.t0 = t0; v.a0 = a0; v.w0 = w0; v.l0 = l0;
    v.t1 = t1; v.a1 = a1; v.w1 = w1; v.l1 = l1;
    v.rdy = rdy; v.rsp = rsp; v.rd = rd;
    v.et = et; v.ea = ea; v.ew = ew; v.el = el; v.ewd = ewd;
    v.r0 = r0; v.s0 = s0; v.rd0 = rd0; v.r1 = r1; v.s1 = s1; v.rd1 = rd1;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    M0_HTRANS = v.t0[1:0]; M0_HADDR = v.a0; M0_HWRITE = v.w0[0]; M0_HMASTLOCK = v.l0[0];
    M1_HTRANS = v.t1[1:0]; M1_HADDR = v.a1; M1_HWRITE = v.w1[0]; M1_HMASTLOCK = v.l1[0];
    HREADY = v.rdy[0]; HRESP = v.rsp[0]; HRDATA = v.rd;
  endtask

  task automatic chkv(input vec_t v, input int i);
    string t;
    t = $sformatf("v%0d", i);
    chk({t, ".htrans"}, 32'(HTRANS), v.et);
    if (v.et != 0) begin
      chk({t, ".haddr"},  HADDR,           v.ea);
      chk({t, ".hwrite"}, 32'(HWRITE),     v.ew);
      chk({t, ".hlock"},  32'(HMASTLOCK),  v.el);
      chk({t, ".hsize"},  32'(HSIZE),      32'd2);
    end
    chk({t, ".hwdata"},    HWDATA,          v.ewd);
    chk({t, ".m0_hready"}, 32'(M0_HREADY),  v.r0);
    chk({t, ".m0_hresp"},  32'(M0_HRESP),   v.s0);
    chk({t, ".m0_hrdata"}, M0_HRDATA,       v.rd0);
    chk({t, ".m1_hready"}, 32'(M1_HREADY),  v.r1);
    chk({t, ".m1_hresp"},  32'(M1_HRESP),   v.s1);
    chk({t, ".m1_hrdata"}, M1_HRDATA,       v.rd1);
  endtask

  initial begin
    // columns: t0 a0 w0 l0 | t1 a1 w1 l1 | rdy rsp rd | et ea ew el ewd | r0 s0 rd0 | r1 s1 rd1
    // M0 single write, zero-wait slave
    vq.push_back(mk(2,'h1000,1,0, 0,0,0,0, 1,0,0, 0,0,0,0,0,          1,0,0, 1,0,0));
    vq.push_back(mk(0,0,0,0,      0,0,0,0, 1,0,0, 0,0,0,0,0,          0,0,0, 1,0,0));
    vq.push_back(mk(0,0,0,0,      0,0,0,0, 1,0,0, 2,'h1000,1,0,0,     0,0,0, 1,0,0));
    vq.push_back(mk(0,0,0,0,      0,0,0,0, 1,0,0, 0,0,0,0,D0,         1,0,0, 1,0,0));
    vq.push_back(mk(0,0,0,0,      0,0,0,0, 1,0,0, 0,0,0,0,0,          1,0,0, 1,0,0));
    // simultaneous reads: M0 first, then the next pair goes to M1 first
    vq.push_back(mk(2,'h2000,0,0, 2,'h3000,0,0, 1,0,0,           0,0,0,0,0,      1,0,0, 1,0,0));
    vq.push_back(mk(0,0,0,0,      0,0,0,0,      1,0,0,           0,0,0,0,0,      0,0,0, 0,0,0));
    vq.push_back(mk(0,0,0,0,      0,0,0,0,      1,0,0,           2,'h2000,0,0,0, 0,0,0, 0,0,0));
    vq.push_back(mk(0,0,0,0,      0,0,0,0,      1,0,'h11111111,  2,'h3000,0,0,D0, 1,0,'h11111111, 0,0,0));
    vq.push_back(mk(0,0,0,0,      0,0,0,0,      1,0,'h22222222,  0,0,0,0,D1,     1,0,0, 1,0,'h22222222));
    vq.push_back(mk(0,0,0,0,      0,0,0,0,      1,0,0,           0,0,0,0,0,      1,0,0, 1,0,0));
    vq.push_back(mk(2,'h4000,0,0, 2,'h5000,0,0, 1,0,0,           0,0,0,0,0,      1,0,0, 1,0,0));
    vq.push_back(mk(0,0,0,0,      0,0,0,0,      1,0,0,           0,0,0,0,0,      0,0,0, 0,0,0));
    vq.push_back(mk(0,0,0,0,      0,0,0,0,      1,0,0,           2,'h5000,0,0,0, 0,0,0, 0,0,0));
    vq.push_back(mk(0,0,0,0,      0,0,0,0,      1,0,'h33333333,  2,'h4000,0,0,D1, 0,0,0, 1,0,'h33333333));
    vq.push_back(mk(0,0,0,0,      0,0,0,0,      1,0,'h44444444,  0,0,0,0,D0,     1,0,'h44444444, 1,0,0));
    vq.push_back(mk(0,0,0,0,      0,0,0,0,      1,0,0,           0,0,0,0,0,      1,0,0, 1,0,0));
    // 3 slave wait states on M0 read; M1 stays in its address phase
    vq.push_back(mk(2,'h6000,0,0, 2,'h7000,0,0, 1,0,0,           0,0,0,0,0,      1,0,0, 1,0,0));
    vq.push_back(mk(0,0,0,0,      0,0,0,0,      1,0,0,           0,0,0,0,0,      0,0,0, 0,0,0));
    vq.push_back(mk(0,0,0,0,      0,0,0,0,      1,0,0,           2,'h6000,0,0,0, 0,0,0, 0,0,0));
    for (int k = 0; k < 3; k++)
      vq.push_back(mk(0,0,0,0,    0,0,0,0,      0,0,0,           2,'h7000,0,0,D0, 0,0,0, 0,0,0));
    vq.push_back(mk(0,0,0,0,      0,0,0,0,      1,0,'hA5A5A5A5,  2,'h7000,0,0,D0, 1,0,'hA5A5A5A5, 0,0,0));
    vq.push_back(mk(0,0,0,0,      0,0,0,0,      1,0,'h5A5A5A5A,  0,0,0,0,D1,     1,0,0, 1,0,'h5A5A5A5A));
    vq.push_back(mk(0,0,0,0,      0,0,0,0,      1,0,0,           0,0,0,0,0,      1,0,0, 1,0,0));
    // two-cycle ERROR response on M1 write
    vq.push_back(mk(0,0,0,0,      2,'h8000,1,0, 1,0,0,           0,0,0,0,0,      1,0,0, 1,0,0));
    vq.push_back(mk(0,0,0,0,      0,0,0,0,      1,0,0,           0,0,0,0,0,      1,0,0, 0,0,0));
    vq.push_back(mk(0,0,0,0,      0,0,0,0,      1,0,0,           2,'h8000,1,0,0, 1,0,0, 0,0,0));
    vq.push_back(mk(0,0,0,0,      0,0,0,0,      0,1,0,           0,0,0,0,D1,     1,0,0, 0,1,0));
    vq.push_back(mk(0,0,0,0,      0,0,0,0,      1,1,0,           0,0,0,0,D1,     1,0,0, 1,1,0));
    vq.push_back(mk(0,0,0,0,      0,0,0,0,      1,0,0,           0,0,0,0,0,      1,0,0, 1,0,0));
    // same master back-to-back: next address captured in the DATA cycle
    vq.push_back(mk(2,'h9000,0,0, 0,0,0,0,      1,0,0,           0,0,0,0,0,      1,0,0, 1,0,0));
    vq.push_back(mk(0,0,0,0,      0,0,0,0,      1,0,0,           0,0,0,0,0,      0,0,0, 1,0,0));
    vq.push_back(mk(0,0,0,0,      0,0,0,0,      1,0,0,           2,'h9000,0,0,0, 0,0,0, 1,0,0));
    vq.push_back(mk(2,'h9004,0,0, 0,0,0,0,      1,0,'h1234,      0,0,0,0,D0,     1,0,'h1234, 1,0,0));
    vq.push_back(mk(0,0,0,0,      0,0,0,0,      1,0,0,           0,0,0,0,0,      0,0,0, 1,0,0));
    vq.push_back(mk(0,0,0,0,      0,0,0,0,      1,0,0,           2,'h9004,0,0,0, 0,0,0, 1,0,0));
    vq.push_back(mk(0,0,0,0,      0,0,0,0,      1,0,'h5678,      0,0,0,0,D0,     1,0,'h5678, 1,0,0));
    vq.push_back(mk(0,0,0,0,      0,0,0,0,      1,0,0,           0,0,0,0,0,      1,0,0, 1,0,0));
    // M0 locked reads while M1 waits (lock build) or alternates (default build)
    vq.push_back(mk(2,'hA000,0,1, 0,0,0,0,      1,0,0, 0,0,0,0,0,                       1,0,0, 1,0,0));
    vq.push_back(mk(0,0,0,0,      2,'hB000,0,0, 1,0,0, 0,0,0,0,0,                       0,0,0, 1,0,0));
    vq.push_back(mk(0,0,0,0,      0,0,0,0,      1,0,0, 2,'hA000,0,LK,0,                 0,0,0, 0,0,0));
    vq.push_back(mk(2,'hA004,0,1, 0,0,0,0,      1,0,0, LK?0:2,'hB000,0,0,D0,            1,0,0, 0,0,0));
    vq.push_back(mk(0,0,0,0,      0,0,0,0,      1,0,0, 0,0,0,0,LK?0:D1,                 0,0,0, LK?0:1,0,0));
    vq.push_back(mk(0,0,0,0,      0,0,0,0,      1,0,0, 2,'hA004,0,LK,0,                 0,0,0, LK?0:1,0,0));
    vq.push_back(mk(2,'hA008,0,0, 0,0,0,0,      1,0,0, 0,0,0,0,D0,                      1,0,0, LK?0:1,0,0));
    vq.push_back(mk(0,0,0,0,      0,0,0,0,      1,0,0, 0,0,0,0,0,                       0,0,0, LK?0:1,0,0));
    vq.push_back(mk(0,0,0,0,      0,0,0,0,      1,0,0, 2,'hA008,0,0,0,                  0,0,0, LK?0:1,0,0));
    vq.push_back(mk(0,0,0,0,      0,0,0,0,      1,0,0, LK?2:0,'hB000,0,0,D0,            1,0,0, LK?0:1,0,0));
    vq.push_back(mk(0,0,0,0,      0,0,0,0,      1,0,0, 0,0,0,0,LK?D1:0,                 1,0,0, 1,0,0));
    vq.push_back(mk(0,0,0,0,      0,0,0,0,      1,0,0, 0,0,0,0,0,                       1,0,0, 1,0,0));

    // reset state, with HRDATA non-zero to show the read data is gated
    M0_HWDATA = D0; M1_HWDATA = D1;
    M0_HSIZE = 3'd2; M1_HSIZE = 3'd2; M0_HPROT = 4'd3; M1_HPROT = 4'd3;
    apply(mk(0,0,0,0, 0,0,0,0, 1,0,'h5555AAAA, 0,0,0,0,0, 0,0,0, 0,0,0));
    @(negedge HCLK);
    chk("rst.htrans",    32'(HTRANS),    32'd0);
    chk("rst.haddr",     HADDR,          32'd0);
    chk("rst.hctl",      32'({HBURST, HWRITE, HSIZE, HPROT, HMASTLOCK}), 32'd0);
    chk("rst.hwdata",    HWDATA,         32'd0);
    chk("rst.m0_hready", 32'(M0_HREADY), 32'd1);
    chk("rst.m1_hready", 32'(M1_HREADY), 32'd1);
    chk("rst.hresp",     32'({M0_HRESP, M1_HRESP}), 32'd0);
    chk("rst.m0_hrdata", M0_HRDATA,      32'd0);
    chk("rst.m1_hrdata", M1_HRDATA,      32'd0);
    @(posedge HCLK); #1;
    HRESET = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      apply(vq[i]);
      @(negedge HCLK);
      chkv(vq[i], i);
      @(posedge HCLK); #1;
    end

    // reset while M0 is in DATA and M1 in ADDR
    apply(mk(2,'hC000,1,0, 0,0,0,0, 1,0,0, 0,0,0,0,0, 0,0,0, 0,0,0));
    @(posedge HCLK); #1;
    apply(mk(0,0,0,0, 2,'hD000,0,0, 1,0,0, 0,0,0,0,0, 0,0,0, 0,0,0));
    @(posedge HCLK); #1;
    apply(mk(0,0,0,0, 0,0,0,0, 1,0,0, 0,0,0,0,0, 0,0,0, 0,0,0));
    @(posedge HCLK); #1;
    @(negedge HCLK);
    chk("mid.pre_htrans",    32'(HTRANS),    32'd2);
    chk("mid.pre_m0_hready", 32'(M0_HREADY), 32'd1);
    chk("mid.pre_hwdata",    HWDATA,         D0);
    HRESET = 1'b1;
    #1;
    chk("mid.htrans",    32'(HTRANS),    32'd0);
    chk("mid.haddr",     HADDR,          32'd0);
    chk("mid.hwdata",    HWDATA,         32'd0);
    chk("mid.m0_hready", 32'(M0_HREADY), 32'd1);
    chk("mid.m1_hready", 32'(M1_HREADY), 32'd1);
    @(posedge HCLK); #1;
    HRESET = 1'b0;
    @(negedge HCLK);
    chk("post.htrans",    32'(HTRANS),    32'd0);
    chk("post.m0_hready", 32'(M0_HREADY), 32'd1);
    chk("post.m1_hready", 32'(M1_HREADY), 32'd1);
    @(posedge HCLK); #1;
    @(negedge HCLK);
    chk("post2.htrans",    32'(HTRANS),    32'd0);
    chk("post2.m0_hready", 32'(M0_HREADY), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
